// File: rtl/mips_run_monitor_if.sv
// mips_run_monitor_if
// CPU-side bus shared by a mips_single_cycle core and the run monitor that
// watches it. The CPU drives the address/data/strobe signals and receives its
// reset from the monitor.
//   inst_adr  : CPU program counter
//   data_adr  : CPU data-memory address
//   data_wr   : CPU store data
//   mem_read  : CPU load strobe
//   mem_write : CPU store strobe
//   cpu_rst   : reset driven back into the CPU by the monitor
// Modports: master = CPU side, slave = monitor side.
interface mips_run_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] inst_adr;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] data_wr;
  logic              mem_read;
  logic              mem_write;
  logic              cpu_rst;

  modport master (
    output inst_adr,
    output data_adr,
    output data_wr,
    output mem_read,
    output mem_write,
    input  cpu_rst
  );

  modport slave (
    input  inst_adr,
    input  data_adr,
    input  data_wr,
    input  mem_read,
    input  mem_write,
    output cpu_rst
  );
endinterface

// File: rtl/mips_run_monitor.sv
// mips_run_monitor
// Run-control and observation block for a single-cycle MIPS test harness.
// Holds the CPU in reset for RST_CYCLES edges, then counts execution cycles,
// loads and stores, captures the latest store to WATCH_ADR, and stops
// counting when the program parks on a self-jump (halt) or runs for
// MAX_CYCLES cycles (timeout).
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : CPU bus (slave modport); cpu_rst is driven from here
//   cycle_cnt  : RUN cycles elapsed
//   rd_cnt     : loads seen while running
//   wr_cnt     : stores seen while running
//   watch_hit  : a store to WATCH_ADR has occurred
//   watch_data : data of the latest store to WATCH_ADR
//   halted     : self-jump detected
//   timeout    : MAX_CYCLES reached without a halt
//   done       : halted | timeout
module mips_run_monitor #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 16,
  parameter int                RST_CYCLES  = 2,
  parameter int                MAX_CYCLES  = 300,
  parameter int                HALT_REPEAT = 3,
  parameter logic [ADDR_W-1:0] WATCH_ADR   = '0
) (
  input  logic              clk,
  input  logic              rst,
  mips_run_monitor_if.slave bus,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              watch_hit,
  output logic [DATA_W-1:0] watch_data,
  output logic              halted,
  output logic              timeout,
  output logic              done
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int REP_W  = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ADDR_W-1:0] prev_adr;
  logic              prev_valid;
  logic [REP_W-1:0]  rep_cnt;

  logic [HOLD_W-1:0] hold_next;
  logic [CNT_W-1:0]  cycle_next;
  logic [CNT_W-1:0]  rd_next;
  logic [CNT_W-1:0]  wr_next;
  logic              rep_match;
  logic [REP_W-1:0]  rep_next;
  logic              halt_det;
  logic              max_reached;
  logic              watch_store;

  // Next-value logic for the RUN state. The repeat counter only ever climbs to
  // HALT_REPEAT before the machine leaves RUN, so it needs no saturation.
  // cycle_cnt cannot reach all-ones either, since the run stops at MAX_CYCLES.
  always_comb begin
    hold_next   = hold_cnt + 1'b1;
    cycle_next  = cycle_cnt + 1'b1;
    rd_next     = (&rd_cnt) ? rd_cnt : rd_cnt + 1'b1;
    wr_next     = (&wr_cnt) ? wr_cnt : wr_cnt + 1'b1;
    rep_match   = prev_valid && (bus.inst_adr == prev_adr);
    rep_next    = rep_match ? rep_cnt + 1'b1 : '0;
    halt_det    = rep_match && (rep_next == REP_W'(HALT_REPEAT));
    max_reached = (cycle_next == CNT_W'(MAX_CYCLES));
    watch_store = bus.mem_write && (bus.data_adr == WATCH_ADR);
  end

  // Main controller. HOLD keeps the CPU in reset while ignoring its bus; RUN
  // samples the bus every edge; HALTED and TIMEOUT freeze everything. The edge
  // that leaves RUN still records that cycle's counts and watch capture, and
  // halt takes priority when both conditions land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_HOLD;
      bus.cpu_rst <= 1'b1;
      hold_cnt    <= '0;
      cycle_cnt   <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      watch_hit   <= 1'b0;
      watch_data  <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      prev_adr    <= '0;
      prev_valid  <= 1'b0;
      rep_cnt     <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          hold_cnt <= hold_next;
          if (hold_next == HOLD_W'(RST_CYCLES)) begin
            state       <= S_RUN;
            bus.cpu_rst <= 1'b0;
            prev_valid  <= 1'b0;
            rep_cnt     <= '0;
          end
        end
        S_RUN: begin
          cycle_cnt  <= cycle_next;
          prev_adr   <= bus.inst_adr;
          prev_valid <= 1'b1;
          rep_cnt    <= rep_next;
          if (bus.mem_read) begin
            rd_cnt <= rd_next;
          end
          if (bus.mem_write) begin
            wr_cnt <= wr_next;
          end
          if (watch_store) begin
            watch_hit  <= 1'b1;
            watch_data <= bus.data_wr;
          end
          if (halt_det) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else if (max_reached) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Both inputs are registers, so the OR cannot glitch.
  assign done = halted | timeout;

endmodule

// File: tb/tb_mips_run_monitor.sv
// tb_mips_run_monitor
// Drives two monitors from the same CPU stimulus:
//   dut 0 : RST_CYCLES=2, MAX_CYCLES=10, HALT_REPEAT=3, WATCH_ADR=0x20
//   dut 1 : RST_CYCLES=2, MAX_CYCLES=5,  HALT_REPEAT=1, WATCH_ADR=0x20
// A behavioural model predicts every output of both monitors and is compared
// on each falling edge; directed literal checks pin the model's key results.
module tb_mips_run_monitor;

  localparam int          RSTC  = 2;
  localparam logic [31:0] WATCH = 32'h20;
  localparam int          SAT   = 65535;

  int p_max[2] = '{10, 5};
  int p_hr[2]  = '{3, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc   = '0;
  logic [31:0] dadr = '0;
  logic [31:0] dwr  = '0;
  logic        mrd  = 1'b0;
  logic        mwr  = 1'b0;
  logic        cmp_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #8 clk = ~clk;

  mips_run_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mips_run_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  // Both buses carry identical CPU-side traffic.
  assign bus_a.inst_adr  = pc;
  assign bus_a.data_adr  = dadr;
  assign bus_a.data_wr   = dwr;
  assign bus_a.mem_read  = mrd;
  assign bus_a.mem_write = mwr;
  assign bus_b.inst_adr  = pc;
  assign bus_b.data_adr  = dadr;
  assign bus_b.data_wr   = dwr;
  assign bus_b.mem_read  = mrd;
  assign bus_b.mem_write = mwr;

  logic [15:0] cyc_o[2];
  logic [15:0] rd_o[2];
  logic [15:0] wr_o[2];
  logic        hit_o[2];
  logic [31:0] wd_o[2];
  logic        halt_o[2];
  logic        to_o[2];
  logic        done_o[2];
  logic        crst_o[2];

  assign crst_o[0] = bus_a.cpu_rst;
  assign crst_o[1] = bus_b.cpu_rst;

  mips_run_monitor #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(16), .RST_CYCLES(RSTC),
    .MAX_CYCLES(10), .HALT_REPEAT(3), .WATCH_ADR(WATCH)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .cycle_cnt(cyc_o[0]), .rd_cnt(rd_o[0]), .wr_cnt(wr_o[0]),
    .watch_hit(hit_o[0]), .watch_data(wd_o[0]),
    .halted(halt_o[0]), .timeout(to_o[0]), .done(done_o[0])
  );

  mips_run_monitor #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(16), .RST_CYCLES(RSTC),
    .MAX_CYCLES(5), .HALT_REPEAT(1), .WATCH_ADR(WATCH)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .cycle_cnt(cyc_o[1]), .rd_cnt(rd_o[1]), .wr_cnt(wr_o[1]),
    .watch_hit(hit_o[1]), .watch_data(wd_o[1]),
    .halted(halt_o[1]), .timeout(to_o[1]), .done(done_o[1])
  );

  // ---------------- behavioural model ----------------
  // m_stable is the length of the current run of identical PC samples; a
  // program is finished once the PC has been seen HALT_REPEAT+1 times in a row.
  int          m_hold[2];
  int          m_cyc[2];
  int          m_rd[2];
  int          m_wr[2];
  int          m_stable[2];
  logic        m_seen[2];
  logic [31:0] m_last[2];
  logic        m_hit[2];
  logic [31:0] m_wd[2];
  logic        m_halt[2];
  logic        m_to[2];

  function automatic int satInc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Model update: reset clears everything, the first RSTC edges are the hold
  // phase, then each edge is one program cycle until the run has ended.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_hold[d] = 0; m_cyc[d] = 0; m_rd[d] = 0; m_wr[d] = 0;
        m_stable[d] = 0; m_seen[d] = 1'b0; m_last[d] = '0;
        m_hit[d] = 1'b0; m_wd[d] = '0; m_halt[d] = 1'b0; m_to[d] = 1'b0;
      end else if (m_halt[d] || m_to[d]) begin
        m_hold[d] = m_hold[d];
      end else if (m_hold[d] < RSTC) begin
        m_hold[d] = m_hold[d] + 1;
      end else begin
        m_cyc[d] = m_cyc[d] + 1;
        if (mrd) m_rd[d] = satInc(m_rd[d]);
        if (mwr) m_wr[d] = satInc(m_wr[d]);
        if (mwr && dadr == WATCH) begin
          m_hit[d] = 1'b1;
          m_wd[d]  = dwr;
        end
        if (m_seen[d] && pc == m_last[d]) m_stable[d] = m_stable[d] + 1;
        else m_stable[d] = 1;
        m_seen[d] = 1'b1;
        m_last[d] = pc;
        if (m_stable[d] >= p_hr[d] + 1) m_halt[d] = 1'b1;
        else if (m_cyc[d] == p_max[d]) m_to[d] = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model comparison on every falling edge, for both monitors.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("d%0d cpu_rst", d), 32'(crst_o[d]), 32'(m_hold[d] < RSTC));
        checkOutput($sformatf("d%0d cycle_cnt", d), 32'(cyc_o[d]), 32'(m_cyc[d]));
        checkOutput($sformatf("d%0d rd_cnt", d), 32'(rd_o[d]), 32'(m_rd[d]));
        checkOutput($sformatf("d%0d wr_cnt", d), 32'(wr_o[d]), 32'(m_wr[d]));
        checkOutput($sformatf("d%0d watch_hit", d), 32'(hit_o[d]), 32'(m_hit[d]));
        checkOutput($sformatf("d%0d watch_data", d), wd_o[d], m_wd[d]);
        checkOutput($sformatf("d%0d halted", d), 32'(halt_o[d]), 32'(m_halt[d]));
        checkOutput($sformatf("d%0d timeout", d), 32'(to_o[d]), 32'(m_to[d]));
        checkOutput($sformatf("d%0d done", d), 32'(done_o[d]), 32'(m_halt[d] | m_to[d]));
      end
    end
  end

  // Present one CPU cycle on the falling edge, then return just after the
  // rising edge that samples it.
  task automatic applyStimulus(input logic [31:0] p, input logic rd, input logic wr,
                               input logic [31:0] adr, input logic [31:0] data);
    @(negedge clk);
    pc = p; mrd = rd; mwr = wr; dadr = adr; dwr = data;
    @(posedge clk);
    #1;
  endtask

  // Reset release 4 units after a falling edge; the bus carries a watched
  // store and a load throughout the hold phase, which must be ignored.
  task automatic doReset();
    rst = 1'b1;
    pc = 32'h100; mrd = 1'b1; mwr = 1'b1; dadr = WATCH; dwr = 32'hdead_beef;
    @(negedge clk);
    #4 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("hold1 cpu_rst", 32'(crst_o[0]), 32'd1);
    checkOutput("hold1 cycle_cnt", 32'(cyc_o[0]), 32'd0);
    @(posedge clk); #1;
    checkOutput("hold2 cpu_rst", 32'(crst_o[0]), 32'd0);
    checkOutput("hold2 cycle_cnt", 32'(cyc_o[0]), 32'd0);
    checkOutput("hold2 watch_hit", 32'(hit_o[0]), 32'd0);
    checkOutput("hold2 wr_cnt", 32'(wr_o[0]), 32'd0);
    checkOutput("hold2 rd_cnt", 32'(rd_o[0]), 32'd0);
  endtask

  // Self-jump program: PC 0,4,8,12,12,12,12. Monitor 1 (HALT_REPEAT=1,
  // MAX_CYCLES=5) sees halt and timeout on the same edge.
  task automatic selfJumpRun();
    logic [31:0] pcs[7] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12, 32'd12};
    for (int k = 0; k < 7; k++) begin
      applyStimulus(pcs[k], 1'b0, 1'b0, 32'h0, 32'h0);
      if (k == 0) checkOutput("first run cycle_cnt", 32'(cyc_o[0]), 32'd1);
      if (k == 4) begin
        checkOutput("sim halted", 32'(halt_o[1]), 32'd1);
        checkOutput("sim timeout", 32'(to_o[1]), 32'd0);
        checkOutput("sim cycle_cnt", 32'(cyc_o[1]), 32'd5);
      end
      if (k == 5) checkOutput("halt early", 32'(halt_o[0]), 32'd0);
    end
    checkOutput("halt halted", 32'(halt_o[0]), 32'd1);
    checkOutput("halt cycle_cnt", 32'(cyc_o[0]), 32'd7);
    checkOutput("halt timeout", 32'(to_o[0]), 32'd0);
    checkOutput("halt done", 32'(done_o[0]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'd16 + 32'(k * 4), 1'b1, 1'b1, WATCH, 32'h55);
    end
    checkOutput("frozen cycle_cnt", 32'(cyc_o[0]), 32'd7);
    checkOutput("frozen wr_cnt", 32'(wr_o[0]), 32'd0);
    checkOutput("frozen watch_hit", 32'(hit_o[0]), 32'd0);
    checkOutput("frozen cpu_rst", 32'(crst_o[0]), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;

    $display("[TB] reset sequence and self-jump halt");
    doReset();
    selfJumpRun();

    $display("[TB] timeout");
    doReset();
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(32'(k * 4), 1'b0, 1'b0, 32'h0, 32'h0);
      if (k == 9) checkOutput("timeout early", 32'(to_o[0]), 32'd0);
      if (k == 10) begin
        checkOutput("timeout flag", 32'(to_o[0]), 32'd1);
        checkOutput("timeout done", 32'(done_o[0]), 32'd1);
        checkOutput("timeout cycle_cnt", 32'(cyc_o[0]), 32'd10);
        checkOutput("timeout halted", 32'(halt_o[0]), 32'd0);
      end
    end
    checkOutput("timeout frozen", 32'(cyc_o[0]), 32'd10);

    $display("[TB] watch capture");
    doReset();
    applyStimulus(32'd0, 1'b0, 1'b1, 32'h20, 32'h5);
    checkOutput("watch first data", wd_o[0], 32'h5);
    applyStimulus(32'd4, 1'b0, 1'b1, 32'h24, 32'h9);
    checkOutput("watch other adr", wd_o[0], 32'h5);
    applyStimulus(32'd8, 1'b1, 1'b0, 32'h40, 32'h0);
    applyStimulus(32'd12, 1'b1, 1'b1, 32'h20, 32'h7);
    applyStimulus(32'd16, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("watch data", wd_o[0], 32'h7);
    checkOutput("watch hit", 32'(hit_o[0]), 32'd1);
    checkOutput("watch wr_cnt", 32'(wr_o[0]), 32'd3);
    checkOutput("watch rd_cnt", 32'(rd_o[0]), 32'd2);

    $display("[TB] reset mid-run");
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(32'(k * 4), 1'b1, 1'b1, WATCH, 32'(k + 1));
    end
    checkOutput("midrun cycle_cnt", 32'(cyc_o[0]), 32'd6);
    #3 rst = 1'b1;
    #2;
    checkOutput("abort cpu_rst", 32'(crst_o[0]), 32'd1);
    checkOutput("abort cycle_cnt", 32'(cyc_o[0]), 32'd0);
    checkOutput("abort wr_cnt", 32'(wr_o[0]), 32'd0);
    checkOutput("abort rd_cnt", 32'(rd_o[0]), 32'd0);
    checkOutput("abort watch_hit", 32'(hit_o[0]), 32'd0);
    checkOutput("abort watch_data", wd_o[0], 32'd0);
    checkOutput("abort done", 32'(done_o[1]), 32'd0);
    doReset();
    selfJumpRun();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Run-time bound so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
